sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock FIFO built around the team's dual-port `ram` block. It owns the write/read pointers, occupancy count, status flags and read-data valid timing. It writes through RAM port a, reads through RAM port b, and presents a plain push/pop interface to the stage that feeds the buffer and the stage that drains it.

## Interface
- `ADDR_WDT`, 4: RAM address width; depth = 2**ADDR_WDT entries.
- `DATA_WDT`, 8: data width.
- `AFULL_TH`, 2**ADDR_WDT-2: `almost_full` asserts when count >= AFULL_TH.
- `AEMPTY_TH`, 2: `almost_empty` asserts when count <= AEMPTY_TH.
- `clk`  in  1  sole clock; also drives RAM `clka` and `clkb`.
- `rst_n`  in  1  asynchronous, active-low reset; RAM `rst` is driven by `!rst_n`.
- `wr_en`  in  1  push request.
- `din`  in  DATA_WDT  push data.
- `rd_en`  in  1  pop request.
- `dout`  out  DATA_WDT  pop data, valid when `dout_vld`=1.
- `dout_vld`  out  1  one-cycle pulse, one cycle after an accepted pop.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1  registered status flags.
- `count`  out  ADDR_WDT+1  current occupancy, 0..2**ADDR_WDT.
- `overflow`, `underflow`  out  1  sticky error flags; present only with SYNC_FIFO_ERR_FLAG_EN.

## Operation
- Pointers `wptr` and `rptr` are ADDR_WDT+1 bits wide. The MSB is a wrap bit; the lower bits are the RAM address.
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc). A push is accepted while full only if a pop is accepted in the same cycle.
- RAM hookup:
  - `wea` = wr_acc, `addra` = wptr[ADDR_WDT-1:0], `dina` = din.
  - `web` = 0, `dinb` = 0, `addrb` = rptr[ADDR_WDT-1:0].
  - `DOUT_REG` = 1.
- RAM port b refreshes its output register every cycle in which `web`=0. `dout` is the RAM `doutb`, qualified only by `dout_vld`.
- On wr_acc, wptr increments by 1. On rd_acc, rptr increments by 1. Both wrap modulo 2**(ADDR_WDT+1).
- Next count = count + wr_acc - rd_acc, computed at ADDR_WDT+1 bits. It never goes negative and never exceeds depth, by construction.
- Flags are registered from the next count:
  - full = (next == 2**ADDR_WDT)
  - empty = (next == 0)
  - almost_full and almost_empty use the thresholds above.
- Push and pop at the same address in the same cycle while full: the read returns the old word, because the RAM reads before it writes. This case is legal.
- Dropped requests leave pointers and count unchanged:
  - rd_en while empty, unless a push is accepted the same cycle: underflow; that push still lands.
  - wr_en while full without a pop: overflow.

## Timing
- Reset values: wptr = rptr = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0 (for AFULL_TH > 0), dout_vld = 0, dout = 0, overflow = underflow = 0.
- Reset asserted mid-operation: all state clears immediately and asynchronously. The RAM output register clears on the next clk edge with `rst` high. Stored RAM contents are not cleared and are treated as garbage.
- Write-to-empty-deassert latency: 1 cycle. A push at edge N gives empty = 0 after edge N.
- Write-to-read latency: data pushed at edge N can be popped at edge N+1. dout_vld = 1 after edge N+2.
- Pop latency: rd_acc at edge N gives dout and dout_vld = 1 after edge N+1. Back-to-back pops give one word per cycle.
- Status flags and count change exactly one edge after the accepted operation. They are not combinational from wr_en or rd_en.

## Configuration
- `SYNC_FIFO_ERR_FLAG_EN`
  - Defined: `overflow` sets on wr_en & !wr_acc and `underflow` sets on rd_en & !rd_acc. Both are sticky until rst_n asserts.
  - Undefined: both ports are absent and dropped requests are silent. All other behaviour is identical.

## Structure
- Shared package `sync_fifo_pkg`: pointer-width constant derivation (ADDR_WDT+1) and the depth constant 2**ADDR_WDT. The same package is reused by a future async FIFO.
- One sub-module: `ram`, instantiated as `u_ram`. Pointer, count and flag logic stays in `sync_fifo`.

## Test plan
Bench uses ADDR_WDT = 2 (depth 4), DATA_WDT = 8, AFULL_TH = 3, AEMPTY_TH = 1.

- Reset release, no traffic -> empty = 1, almost_empty = 1, full = 0, count = 0, dout_vld = 0, dout = 0x00.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> after the 3rd push almost_full = 1; after the 4th full = 1 and count = 4. A 5th push of 0x55 is dropped, and overflow = 1 if the macro is defined.
- From full, pop 4 times -> dout sequence 0x11, 0x22, 0x33, 0x44, each with dout_vld one cycle after its rd_en. Then empty = 1. A further pop gives underflow = 1 and no dout_vld.
- Full FIFO with wr_en = rd_en = 1 for 6 cycles, data 0xA0..0xA5 -> count stays 4, full stays 1, dout returns the oldest entries in order, and no overflow is flagged.
- Empty FIFO with wr_en = rd_en = 1 pushing 0x77 -> pop is rejected and 0x77 is stored, giving count = 1 and empty = 0. The next cycle's pop returns 0x77.
- Assert rst_n low while holding 3 entries, then release -> count = 0 and empty = 1 immediately. A later push and pop of 0x5A returns 0x5A, so pointers restart at 0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module : sync_fifo_pkg
// Brief  : Shared FIFO sizing helpers and status-flag type (sync and async FIFOs)
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

  // Pointer carries one wrap bit above the RAM address.
  function automatic int ptr_wdt(input int addr_wdt);
    return addr_wdt + 1;
  endfunction

  function automatic int depth_of(input int addr_wdt);
    return 1 << addr_wdt;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_if.sv
// ============================================================================
// Module : sync_fifo_if
// Brief  : Push/pop bus; overflow/underflow exist only with SYNC_FIFO_ERR_FLAG_EN
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WDT = 4,
  parameter int DATA_WDT = 8
);
  logic                              wr_en;
  logic [DATA_WDT-1:0]               din;
  logic                              rd_en;
  logic [DATA_WDT-1:0]               dout;
  logic                              dout_vld;
  logic                              full;
  logic                              empty;
  logic                              almost_full;
  logic                              almost_empty;
  logic [ptr_wdt(ADDR_WDT)-1:0]      count;
`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic                              overflow;
  logic                              underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, dout_vld, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, dout_vld, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output wr_en, din, rd_en,
    input  dout, dout_vld, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, dout_vld, full, empty, almost_full, almost_empty, count
  );
`endif

endinterface

`default_nettype wire

// File: rtl/ram.sv
// ============================================================================
// Module : ram
// Brief  : Dual-port RAM, read-before-write, sync read plus optional output reg
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram #(
  parameter int ADDR_WDT = 4,
  parameter int DATA_WDT = 8,
  parameter int DOUT_REG = 1
) (
  input  wire logic                clka,
  input  wire logic                clkb,
  input  wire logic                rst,
  input  wire logic                wea,
  input  wire logic [ADDR_WDT-1:0] addra,
  input  wire logic [DATA_WDT-1:0] dina,
  input  wire logic                web,
  input  wire logic [ADDR_WDT-1:0] addrb,
  input  wire logic [DATA_WDT-1:0] dinb,
  output logic      [DATA_WDT-1:0] doutb
);

  logic [DATA_WDT-1:0] mem_q [2**ADDR_WDT];
  logic [DATA_WDT-1:0] rd_q;

  // Both write ports commit in one process so the array has a single driver.
  always_ff @(posedge clka) begin
    if (wea) mem_q[addra] <= dina;
    if (web) mem_q[addrb] <= dinb;
  end

  always_ff @(posedge clkb) begin
    if (rst)       rd_q <= '0;
    else if (!web) rd_q <= mem_q[addrb];
  end

  generate
    if (DOUT_REG != 0) begin : g_dout_reg
      logic [DATA_WDT-1:0] out_q;
      always_ff @(posedge clkb) begin
        if (rst)       out_q <= '0;
        else if (!web) out_q <= rd_q;
      end
      assign doutb = out_q;
    end else begin : g_dout_comb
      assign doutb = rd_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO over ram; sticky error flags with SYNC_FIFO_ERR_FLAG_EN
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WDT  = 4,
  parameter int DATA_WDT  = 8,
  parameter int AFULL_TH  = 2**ADDR_WDT - 2,
  parameter int AEMPTY_TH = 2
) (
  input wire logic  clk,
  input wire logic  rst_n,
  sync_fifo_if.slave bus
);

  localparam int PTR_WDT = ptr_wdt(ADDR_WDT);
  localparam int DEPTH   = depth_of(ADDR_WDT);

  localparam fifo_flags_t FLAGS_RST = '{
    full:   1'b0,
    empty:  1'b1,
    afull:  (AFULL_TH <= 0),
    aempty: (AEMPTY_TH >= 0)
  };

  logic                wr_acc;
  logic                rd_acc;
  logic [PTR_WDT-1:0]  wptr_q,  wptr_d;
  logic [PTR_WDT-1:0]  rptr_q,  rptr_d;
  logic [PTR_WDT-1:0]  count_q, count_d;
  fifo_flags_t         flags_q, flags_d;
  logic                rd_pend_q, rd_pend_d;
  logic                dout_vld_q, dout_vld_d;
  logic [DATA_WDT-1:0] ram_doutb;

  always_comb begin
    rd_acc  = bus.rd_en & ~flags_q.empty;
    // A push while full is taken only when a pop frees a slot this cycle.
    wr_acc  = bus.wr_en & (~flags_q.full | rd_acc);

    wptr_d  = wptr_q + PTR_WDT'(wr_acc);
    rptr_d  = rptr_q + PTR_WDT'(rd_acc);
    count_d = count_q + PTR_WDT'(wr_acc) - PTR_WDT'(rd_acc);

    flags_d.full   = (count_d == PTR_WDT'(DEPTH));
    flags_d.empty  = (count_d == '0);
    flags_d.afull  = (int'(count_d) >= AFULL_TH);
    flags_d.aempty = (int'(count_d) <= AEMPTY_TH);

    // Two RAM register stages between an accepted pop and valid data.
    rd_pend_d  = rd_acc;
    dout_vld_d = rd_pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      flags_q    <= FLAGS_RST;
      rd_pend_q  <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
      rd_pend_q  <= rd_pend_d;
      dout_vld_q <= dout_vld_d;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (bus.wr_en & ~wr_acc);
    underflow_d = underflow_q | (bus.rd_en & ~rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

  ram #(
    .ADDR_WDT (ADDR_WDT),
    .DATA_WDT (DATA_WDT),
    .DOUT_REG (1)
  ) u_ram (
    .clka  (clk),
    .clkb  (clk),
    .rst   (!rst_n),
    .wea   (wr_acc),
    .addra (wptr_q[ADDR_WDT-1:0]),
    .dina  (bus.din),
    .web   (1'b0),
    .addrb (rptr_q[ADDR_WDT-1:0]),
    .dinb  ({DATA_WDT{1'b0}}),
    .doutb (ram_doutb)
  );

  assign bus.dout         = ram_doutb;
  assign bus.dout_vld     = dout_vld_q;
  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.afull;
  assign bus.almost_empty = flags_q.aempty;
  assign bus.count        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module : tb_sync_fifo
// Brief  : Scoreboard bench for sync_fifo (depth 4); honours SYNC_FIFO_ERR_FLAG_EN
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sync_fifo_if #(.ADDR_WDT(2), .DATA_WDT(8)) bus ();

  sync_fifo #(
    .ADDR_WDT  (2),
    .DATA_WDT  (8),
    .AFULL_TH  (3),
    .AEMPTY_TH (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] model_q [$];
  logic [7:0] sb_q [$];
  logic       pend;
  logic       exp_vld;
  logic       exp_ovf;
  logic       exp_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    int sz = model_q.size();
    check("count",        32'(bus.count),     32'(sz));
    check("full",         32'(bus.full),      32'(sz == 4));
    check("empty",        32'(bus.empty),     32'(sz == 0));
    check("almost_full",  32'(bus.almost_full),  32'(sz >= 3));
    check("almost_empty", 32'(bus.almost_empty), 32'(sz <= 1));
`ifdef SYNC_FIFO_ERR_FLAG_EN
    check("overflow",     32'(bus.overflow),  32'(exp_ovf));
    check("underflow",    32'(bus.underflow), 32'(exp_unf));
`endif
  endtask

  // One clock of traffic; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    logic rd_ok, wr_ok;
    bus.wr_en = w;
    bus.din   = d;
    bus.rd_en = r;
    rd_ok = r && (model_q.size() > 0);
    wr_ok = w && ((model_q.size() < 4) || rd_ok);
    @(posedge clk);
    if (w && !wr_ok) exp_ovf = 1'b1;
    if (r && !rd_ok) exp_unf = 1'b1;
    if (rd_ok) sb_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    exp_vld = pend;
    pend    = rd_ok;
    #1;
    check_status();
    check("dout_vld", 32'(bus.dout_vld), 32'(exp_vld));
    if (exp_vld) begin
      if (sb_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
      else                  check("dout", 32'(bus.dout), 32'(sb_q.pop_front()));
    end
  endtask

  // Asynchronous assert mid-cycle, checked before any clock edge.
  task automatic do_reset();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    sb_q.delete();
    pend = 1'b0; exp_vld = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    check_status();
    check("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 32'(bus.dout), 32'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = 8'h00;
    pend = 1'b0; exp_vld = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_status();
    check("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
    check("rst_dout",     32'(bus.dout),     32'h00);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);

    // Fill, then an overflowing push.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i * 8'h11), 1'b0);
    cycle(1'b1, 8'h55, 1'b0);

    // Drain, then an underflowing pop.
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Full with simultaneous push/pop (same RAM address each cycle).
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);

    // Empty with simultaneous push/pop: pop rejected, push lands.
    cycle(1'b1, 8'h77, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);

    // Reset while holding three entries, then reuse.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset();
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
